// File: rtl/add_pkg.sv
// Shared definitions for the sequential multi-limb adder.
// Holds the limb width, the default limb count and the FSM state encoding.
package add_pkg;

    localparam int unsigned LIMB_W     = 32;
    localparam int unsigned NWORDS_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/add32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
// Ports:
//   Ain, Bin : 32-bit addends
//   cin      : carry in
//   s        : 32-bit sum
//   cout     : carry out of bit 31
module add32 (
    input  logic [31:0] Ain,
    input  logic [31:0] Bin,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // Per-group lookahead: every carry inside a group is derived from the group's carry-in.
    always_comb begin
        g = Ain & Bin;
        p = Ain ^ Bin;
        c = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign s    = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/add_seq.sv
// Sequential NWORDS x 32-bit adder: one add32 is time-shared across the limbs,
// one limb per cycle, starting with limb 0.
// Optional feature: define ADD_SEQ_SUB_EN to add the sub port (A - B).
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted in IDLE only)
//   a_in, b_in, cin      : operands (limb 0 = bits [31:0]) and carry in
//   sub                  : subtract request (ADD_SEQ_SUB_EN only)
//   out_valid / out_ready: result handshake
//   sum, cout            : result and carry out of the top limb
//   busy                 : operation in progress or result pending
module add_seq
    import add_pkg::*;
#(
    parameter int unsigned NWORDS = NWORDS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LIMB_W*NWORDS-1:0]   a_in,
    input  logic [LIMB_W*NWORDS-1:0]   b_in,
    input  logic                       cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                       sub,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LIMB_W*NWORDS-1:0]   sum,
    output logic                       cout,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NWORDS);
    localparam int unsigned LAST  = NWORDS - 1;

    state_t                         state_q, state_n;
    logic [NWORDS-1:0][LIMB_W-1:0]  a_q, a_n;
    logic [NWORDS-1:0][LIMB_W-1:0]  b_q, b_n;
    logic [NWORDS-1:0][LIMB_W-1:0]  sum_q, sum_n;
    logic [IDX_W-1:0]               idx_q, idx_n;
    logic                           carry_q, carry_n;
    logic                           cout_q, cout_n;
    logic                           in_ready_n, out_valid_n, busy_n;

    logic [LIMB_W-1:0]              add_b;
    logic [LIMB_W-1:0]              add_s;
    logic                           add_co;

`ifdef ADD_SEQ_SUB_EN
    logic                           sub_q, sub_n;

    // Subtraction is A + ~B + 1; the +1 comes from the carry register at acceptance.
    assign add_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
    assign add_b = b_q[idx_q];
`endif

    add32 u_add32 (
        .Ain  (a_q[idx_q]),
        .Bin  (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        sum_n   = sum_q;
        idx_n   = idx_q;
        carry_n = carry_q;
        cout_n  = cout_q;
`ifdef ADD_SEQ_SUB_EN
        sub_n   = sub_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_n     = a_in;
                    b_n     = b_in;
                    carry_n = cin;
                    idx_n   = '0;
`ifdef ADD_SEQ_SUB_EN
                    sub_n   = sub;
                    if (sub) begin
                        carry_n = 1'b1;
                    end
`endif
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                sum_n[idx_q] = add_s;
                carry_n      = add_co;
                idx_n        = IDX_W'(idx_q + 1'b1);
                if (idx_q == IDX_W'(LAST)) begin
                    cout_n  = add_co;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Handshake flags follow the next state so they are registered with it.
        in_ready_n  = (state_n == S_IDLE);
        out_valid_n = (state_n == S_DONE);
        busy_n      = (state_n != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            a_q       <= a_n;
            b_q       <= b_n;
            sum_q     <= sum_n;
            idx_q     <= idx_n;
            carry_q   <= carry_n;
            cout_q    <= cout_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
`ifdef ADD_SEQ_SUB_EN
            sub_q     <= sub_n;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq with NWORDS = 4 (128-bit operands).
// Subtraction vectors are included when ADD_SEQ_SUB_EN is defined.
module tb_add_seq;

    localparam int unsigned NW = 4;
    localparam int unsigned W  = 32 * NW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    add_seq #(.NWORDS(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic ci, logic sb,
                                logic [W-1:0] es, logic ec);
        vec_t v;
        v.a = a; v.b = b; v.ci = ci; v.sb = sb; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer operands for one edge (accepted from IDLE), then scramble the inputs.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb);
        a_in = a; b_in = b; cin = ci; sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_in = {4{$urandom()}};
        b_in = {4{$urandom()}};
        cin  = 1'b1;
        sub  = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    logic [W-1:0] ones;

    initial begin
        ones      = '1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        chk("reset_in_ready",  W'(in_ready),  W'(1));
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_busy",      W'(busy),      W'(0));
        chk("reset_sum",       sum,           '0);
        chk("reset_cout",      W'(cout),      W'(0));
        reset = 1'b0;
        tick();
        chk("post_reset_in_ready", W'(in_ready), W'(1));

        vecs.push_back(mk(128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
                          128'h0000_0002_0000_0000_0000_0000_0000_0000, 1'b0));
        vecs.push_back(mk(ones, '0, 1'b1, 1'b0, '0, 1'b1));
        vecs.push_back(mk(ones, 128'h1, 1'b0, 1'b0, '0, 1'b1));
        vecs.push_back(mk('0, '0, 1'b0, 1'b0, '0, 1'b0));
        vecs.push_back(mk(128'h8000_0000_0000_0000_0000_0000_0000_0000,
                          128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, '0, 1'b1));
        vecs.push_back(mk(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                          128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0, 1'b0,
                          128'h1234_5678_9ABC_DF00_1122_3344_5566_7788, 1'b0));
        vecs.push_back(mk(128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF, '0, 1'b1, 1'b0,
                          128'h0000_0000_FFFF_FFFF_0000_0001_0000_0000, 1'b0));
`ifdef ADD_SEQ_SUB_EN
        vecs.push_back(mk(128'h5, 128'h7, 1'b0, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0));
        vecs.push_back(mk(128'h7, 128'h5, 1'b0, 1'b1, 128'h2, 1'b1));
        vecs.push_back(mk(128'h1_0000_0000, 128'h1, 1'b1, 1'b1, 128'hFFFF_FFFF, 1'b1));
`endif

        // Table-driven operations with latency and handshake checks.
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb);
            chk($sformatf("v%0d_run_in_ready", i), W'(in_ready), W'(0));
            wait_done(cyc);
            chk($sformatf("v%0d_latency", i), W'(cyc), W'(NW));
            chk($sformatf("v%0d_sum", i), sum, vecs[i].es);
            chk($sformatf("v%0d_cout", i), W'(cout), W'(vecs[i].ec));
            chk($sformatf("v%0d_busy", i), W'(busy), W'(1));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_release", i), W'({out_valid, in_ready}), W'(2'b01));
        end

        // Result held in DONE while out_ready is low; in_valid pulses ignored.
        start_op(ones, 128'h1, 1'b0, 1'b0);
        wait_done(cyc);
        chk("hold_latency", W'(cyc), W'(NW));
        for (int k = 0; k < 5; k++) begin
            a_in = 128'h1234; b_in = 128'h1; in_valid = k[0];
            tick();
            chk($sformatf("hold%0d_flags", k), W'({out_valid, in_ready, busy}), W'(3'b101));
            chk($sformatf("hold%0d_sum", k), sum, '0);
            chk($sformatf("hold%0d_cout", k), W'(cout), W'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("hold_exit_idle", W'({out_valid, in_ready, busy}), W'(3'b010));

        // Reset in the second RUN cycle abandons the operation.
        start_op(128'h5, 128'h6, 1'b0, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset_flags", W'({out_valid, in_ready, busy}), W'(3'b010));
        chk("midrun_reset_sum",   sum, '0);
        chk("midrun_reset_cout",  W'(cout), W'(0));
        tick();
        reset = 1'b0;
        tick();
        chk("midrun_post_in_ready", W'(in_ready), W'(1));
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("midrun_no_out_valid", W'(seen), W'(0));
        end

        // Back-to-back: second operation waits on the DONE->IDLE transition.
        start_op(128'h3, 128'h4, 1'b0, 1'b0);
        wait_done(cyc);
        chk("b2b_first_sum", sum, 128'h7);
        out_ready = 1'b1;
        a_in = 128'hFFFF_FFFF; b_in = 128'h1; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        chk("b2b_idle_gap", W'({out_valid, in_ready, busy}), W'(3'b010));
        tick();
        chk("b2b_accepted", W'({in_ready, busy}), W'(2'b01));
        in_valid = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0;
        wait_done(cyc);
        chk("b2b_latency", W'(cyc), W'(NW));
        chk("b2b_sum",  sum, 128'h1_0000_0001);
        chk("b2b_cout", W'(cout), W'(0));
        tick();
        out_ready = 1'b0;
        chk("b2b_exit", W'({out_valid, in_ready}), W'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
